// File: rtl/reg_file_bank.sv
// Two-read/one-write parametrised register file with post-reset clear sequencer,
// same-cycle write-to-read bypass, optional hardwired zero register and signed immediates.
module reg_file_bank #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int IMM_W   = 8,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        func,
  input  logic              rd_en,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              imm_sext,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic              wr_en,
  input  logic              wr_load,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] load_in,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] store_in,
  output logic              out_valid,
  output logic              busy
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] ra_data, rb_data, st_data;
  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  assign busy    = (state == CLEAR);
  assign wr_data = wr_load ? load_in : wb_data;
  assign wr_ok   = (state == READY) && wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

  generate
    if (DATA_W > IMM_W) begin : g_ext
      assign imm_ext = {{(DATA_W-IMM_W){imm_sext & imm_in[IMM_W-1]}}, imm_in};
    end else begin : g_noext
      assign imm_ext = imm_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (state == CLEAR && cnt == {ADDR_W{1'b1}}) next_state = READY;
  end

  // The single array write port is shared between the clear sequencer and normal writes.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_data = wr_data;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = cnt;
      mem_data = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) regs[mem_addr] <= mem_data;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if ((ZERO_R0 != 0) && (addr == '0)) return '0;
    if (wr_ok && (addr == wr_addr))     return wr_data;
    return regs[addr];
  endfunction

  always_comb begin
    ra_data = read_port(ra_addr);
    rb_data = read_port(rb_addr);
    st_data = read_port(st_addr);
  end

  // Untargeted outputs hold; out_valid only pulses for the three defined read kinds.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in1   <= '0;
      alu_in2   <= '0;
      store_in  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == READY && rd_en) begin
        case (func)
          2'b00: begin
            alu_in1   <= ra_data;
            alu_in2   <= rb_data;
            out_valid <= 1'b1;
          end
          2'b01: begin
            alu_in1   <= ra_data;
            alu_in2   <= imm_ext;
            out_valid <= 1'b1;
          end
          2'b10: begin
            store_in  <= st_data;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank (ADDR_W=4, ZERO_R0=1): table-driven vectors
// scored through an expectation queue, plus hand-written reset and clear sequences.
module tb_reg_file_bank;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int IMM_W  = 8;
  localparam int NREG   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        func;
  logic              rd_en;
  logic [IMM_W-1:0]  imm_in;
  logic              imm_sext;
  logic [ADDR_W-1:0] ra_addr, rb_addr, st_addr, wr_addr;
  logic              wr_en, wr_load;
  logic [DATA_W-1:0] wb_data, load_in;
  logic [DATA_W-1:0] alu_in1, alu_in2, store_in;
  logic              out_valid, busy;

  reg_file_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .func(func), .rd_en(rd_en), .imm_in(imm_in), .imm_sext(imm_sext),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .st_addr(st_addr), .wr_en(wr_en), .wr_load(wr_load),
    .wr_addr(wr_addr), .wb_data(wb_data), .load_in(load_in), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .store_in(store_in), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  func;
    logic        rd_en;
    logic [7:0]  imm;
    logic        sext;
    logic [3:0]  ra, rb, st;
    logic        wr_en, wr_load;
    logic [3:0]  wa;
    logic [15:0] wb, ld;
    logic [15:0] ea, eb, es;
    logic        ev;
  } vec_t;

  typedef struct {
    logic [15:0] a, b, s;
    logic        v, busy;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [1:0] f, logic re, logic [7:0] imm, logic sx,
                              logic [3:0] ra, logic [3:0] rb, logic [3:0] st,
                              logic we, logic wl, logic [3:0] wa, logic [15:0] wb, logic [15:0] ld,
                              logic [15:0] ea, logic [15:0] eb, logic [15:0] es, logic ev);
    vec_t v;
    v.func = f; v.rd_en = re; v.imm = imm; v.sext = sx;
    v.ra = ra; v.rb = rb; v.st = st;
    v.wr_en = we; v.wr_load = wl; v.wa = wa; v.wb = wb; v.ld = ld;
    v.ea = ea; v.eb = eb; v.es = es; v.ev = ev;
    return v;
  endfunction

  task automatic compare(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    func = v.func; rd_en = v.rd_en; imm_in = v.imm; imm_sext = v.sext;
    ra_addr = v.ra; rb_addr = v.rb; st_addr = v.st;
    wr_en = v.wr_en; wr_load = v.wr_load; wr_addr = v.wa; wb_data = v.wb; load_in = v.ld;
    e.a = v.ea; e.b = v.eb; e.s = v.es; e.v = v.ev; e.busy = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty got %h want entry", name, alu_in1);
      return;
    end
    e = exp_q.pop_front();
    compare({name, ".alu_in1"},   alu_in1,          e.a);
    compare({name, ".alu_in2"},   alu_in2,          e.b);
    compare({name, ".store_in"},  store_in,         e.s);
    compare({name, ".out_valid"}, {15'd0, out_valid}, {15'd0, e.v});
    compare({name, ".busy"},      {15'd0, busy},    {15'd0, e.busy});
  endtask

  // Reset while requests and a write to R1 are being driven; they must all be ignored.
  task automatic pulseReset(input string name);
    exp_t e;
    @(negedge clk);
    rst = 1'b1; rd_en = 1'b1; func = 2'b00; ra_addr = 4'd3; rb_addr = 4'd7;
    wr_en = 1'b1; wr_load = 1'b0; wr_addr = 4'd1; wb_data = 16'hDEAD;
    e.a = '0; e.b = '0; e.s = '0; e.v = 1'b0; e.busy = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    checkOutput(name);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitClear(input int limit, output int n, output int bad_valid);
    n = 0;
    bad_valid = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      n++;
      if (out_valid !== 1'b0) bad_valid++;
      if (busy === 1'b0) break;
    end
  endtask

  initial begin
    int n, bad;
    rst = 1'b1; func = '0; rd_en = 0; imm_in = '0; imm_sext = 0;
    ra_addr = '0; rb_addr = '0; st_addr = '0; wr_en = 0; wr_load = 0; wr_addr = '0;
    wb_data = '0; load_in = '0;
    repeat (2) @(posedge clk);

    pulseReset("reset0");
    waitClear(40, n, bad);
    compare("clear_cycles", n[15:0], NREG[15:0]);
    compare("clear_valid", bad[15:0], 16'd0);

    // Restart the clear after 10 cycles; the full NREG cycles must follow the second release.
    pulseReset("reset_mid");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) bad++;
    end
    compare("clear_busy_early", bad[15:0], 16'd0);
    pulseReset("reset_mid2");
    waitClear(40, n, bad);
    compare("clear_restart_cycles", n[15:0], NREG[15:0]);
    compare("clear_restart_valid", bad[15:0], 16'd0);

    //           f     re   imm    sx  ra  rb  st  we  wl  wa  wb        ld        ea        eb        es        ev
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 5, 15, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1));
    vecs.push_back(mk(2'b00, 0, 8'h00, 0, 0, 0,  0, 1, 0, 3, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(2'b00, 0, 8'h00, 0, 0, 0,  0, 1, 1, 7, 16'hFFFF, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 3, 7,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF, 16'h0000, 1));
    vecs.push_back(mk(2'b00, 0, 8'h00, 0, 0, 0,  0, 1, 0, 2, 16'h0001, 16'h0000, 16'h1234, 16'hBEEF, 16'h0000, 0));
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 2, 3,  0, 1, 0, 2, 16'h00AA, 16'h0000, 16'h00AA, 16'h1234, 16'h0000, 1));
    vecs.push_back(mk(2'b00, 0, 8'h00, 0, 0, 0,  0, 1, 0, 2, 16'h0001, 16'h0000, 16'h00AA, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(2'b10, 1, 8'h00, 0, 0, 0,  2, 1, 0, 2, 16'h00AA, 16'h0000, 16'h00AA, 16'h1234, 16'h00AA, 1));
    vecs.push_back(mk(2'b00, 0, 8'h00, 0, 0, 0,  0, 1, 0, 4, 16'h0010, 16'h0000, 16'h00AA, 16'h1234, 16'h00AA, 0));
    vecs.push_back(mk(2'b01, 1, 8'hF0, 1, 4, 0,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 16'hFFF0, 16'h00AA, 1));
    vecs.push_back(mk(2'b01, 1, 8'hF0, 0, 4, 0,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 16'h00F0, 16'h00AA, 1));
    vecs.push_back(mk(2'b01, 1, 8'h7F, 1, 3, 0,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 16'h007F, 16'h00AA, 1));
    vecs.push_back(mk(2'b00, 0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 16'h5555, 16'h0000, 16'h1234, 16'h007F, 16'h00AA, 0));
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 0, 4,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h00AA, 1));
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 0, 0,  0, 1, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h00AA, 1));
    vecs.push_back(mk(2'b11, 1, 8'h00, 0, 3, 7,  7, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00AA, 0));
    vecs.push_back(mk(2'b10, 1, 8'h00, 0, 3, 3,  7, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1));
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 15, 15, 0, 1, 1, 15, 16'h0000, 16'h8001, 16'h8001, 16'h8001, 16'hBEEF, 1));
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 15, 3, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h8001, 16'h1234, 16'hBEEF, 1));
    vecs.push_back(mk(2'b00, 0, 8'h00, 0, 0, 0,  0, 1, 0, 1, 16'h9999, 16'h0000, 16'h8001, 16'h1234, 16'hBEEF, 0));
    vecs.push_back(mk(2'b00, 1, 8'h00, 0, 1, 1,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h9999, 16'h9999, 16'hBEEF, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", i));
    end

    // Reset from READY clears outputs and the array; R1 must read back as zero.
    pulseReset("reset_ready");
    waitClear(40, n, bad);
    compare("clear_ready_cycles", n[15:0], NREG[15:0]);
    applyStimulus(mk(2'b00, 1, 8'h00, 0, 1, 7, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1));
    @(posedge clk); #1;
    checkOutput("post_reset_read");
    applyStimulus(mk(2'b00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
    @(posedge clk); #1;
    checkOutput("idle_valid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
Name: reg_file_bank

Overview:
- Parametrised two-read/one-write register file feeding the ALU operand latches and the store data path. It is the successor to the fixed 256x16 register file.
- Adds the following over the fixed version:
  - configurable data, address and immediate widths;
  - a hardware clear sequencer after reset;
  - same-cycle write-to-read bypass;
  - optional hardwired zero register;
  - signed immediates;
  - an output valid strobe.
- Sits between the instruction decoder (func, addresses, immediate) and the ALU/memory stage.

Parameters:
- DATA_W, 16, register and operand width in bits
- ADDR_W, 8, register address width; depth NREG = 2**ADDR_W
- IMM_W, 8, immediate width; IMM_W <= DATA_W
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- func  in  2  00 reg-reg read, 01 reg-imm read, 10 store read, 11 reserved
- rd_en  in  1  issue a read for func this cycle
- imm_in  in  IMM_W  immediate operand
- imm_sext  in  1  1 = sign-extend imm_in, 0 = zero-extend
- ra_addr  in  ADDR_W  source A address
- rb_addr  in  ADDR_W  source B address
- st_addr  in  ADDR_W  store source address
- wr_en  in  1  write request
- wr_load  in  1  1 = write load_in, 0 = write wb_data
- wr_addr  in  ADDR_W  destination address
- wb_data  in  DATA_W  ALU writeback data
- load_in  in  DATA_W  memory load data
- alu_in1  out  DATA_W  operand A
- alu_in2  out  DATA_W  operand B
- store_in  out  DATA_W  store data
- out_valid  out  1  one-cycle strobe: outputs updated by the previous-cycle read
- busy  out  1  clear sequencer running; all requests ignored

Behaviour:
- Reset (rst=1 at an edge):
  - alu_in1, alu_in2, store_in and out_valid go to 0, and busy goes to 1.
  - FSM enters CLEAR and the clear counter is set to 0.
  - Reset asserted mid-CLEAR restarts the counter at 0.
- FSM has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to regfile[cnt] and increments cnt. After the write of NREG-1 the FSM moves to READY, and busy falls on that same edge. The clear therefore takes exactly NREG cycles after rst deasserts.
  - CLEAR: rd_en and wr_en are ignored, and out_valid stays 0.
  - READY: normal operation; it never returns to CLEAR except via rst.
- Read (READY, rd_en=1), registered with 1-cycle latency:
  - func 00: alu_in1 = R[ra_addr] and alu_in2 = R[rb_addr].
  - func 01: alu_in1 = R[ra_addr] and alu_in2 = ext(imm_in).
  - func 10: store_in = R[st_addr].
  - In all three cases out_valid = 1 on the next cycle.
  - func 11: no output change and out_valid = 0.
- Outputs not targeted by the current func hold their previous value.
- out_valid = 0 in any cycle following rd_en = 0.
- Immediate extension:
  - imm_sext = 1 replicates imm_in[IMM_W-1] into the upper DATA_W-IMM_W bits.
  - imm_sext = 0 pads those bits with zeros.
- Write (READY, wr_en=1): R[wr_addr] <= wr_load ? load_in : wb_data. Write and read may occur in the same cycle, independently of func.
- Bypass: if wr_en=1 and a read address equals wr_addr in the same cycle, that operand returns the new write data, not the old contents. This applies independently to ra_addr, rb_addr and st_addr.
- ZERO_R0=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, with no bypass applied.
- No other arbitration is needed; there is one write port only.

Test Plan:
- Clear sequence, ADDR_W=4: pulse rst for 1 cycle → busy=1 for exactly 16 cycles. Then a func 00 read with ra=5, rb=15 → alu_in1=0, alu_in2=0, out_valid=1 one cycle after rd_en.
- Write/read:
  - Cycle 1: wr_en with wr_addr=3, wb_data=0x1234, wr_load=0.
  - Cycle 2: wr_en with wr_addr=7, load_in=0xBEEF, wr_load=1.
  - Cycle 3: func 00 read with ra=3, rb=7 → next cycle alu_in1=0x1234, alu_in2=0xBEEF.
- Bypass: R2=0x0001. In one cycle, wr_en with wr_addr=2, wb_data=0x00AA, together with a func 00 read with ra=2 → alu_in1=0x00AA. Repeat with func 10 and st_addr=2 → store_in=0x00AA.
- Immediate: R4=0x0010, func 01, ra=4, imm_in=0xF0.
  - imm_sext=1 → alu_in2=0xFFF0, alu_in1=0x0010.
  - imm_sext=0 → alu_in2=0x00F0.
- ZERO_R0=1: write 0x5555 to address 0, then read ra=0 → alu_in1=0. A same-cycle write+read of address 0 also returns 0.
- Reset mid-operation:
  - Assert rst at clear cycle 10 → busy stays high for a full NREG cycles after release.
  - Assert rst in READY after writing R1=0x9999 → outputs become 0, and a later read of R1 returns 0.
